datapath_controller: RTL and testbench

- Instruction sequencer that drives the datapath control bus automatically, replacing manual switch-driven control of register-read, execute and writeback stages.
- Accepts one 16-bit instruction per start/busy/done handshake.
- Steps a Moore FSM that asserts exactly one datapath stage per cycle, then signals completion.
- Sits between an instruction source (register or memory) and the datapath; its outputs connect one-to-one to the datapath control inputs and datapath_in.

---
 rtl/datapath_controller_if.sv | 36 +++
 rtl/datapath_controller.sv | 162 ++++++++++++++++
 tb/tb_datapath_controller.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_controller_if.sv
// Control bus between the instruction source, the sequencer and the datapath.
// master = sequencer side, slave = instruction source / datapath side.
interface datapath_controller_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  start;
   logic [15:0]           instr;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [2:0]            readnum;
   logic [2:0]            writenum;
   logic                  write;
   logic                  vsel;
   logic                  loada;
   logic                  loadb;
   logic                  asel;
   logic                  bsel;
   logic [1:0]            shift;
   logic [1:0]            ALUop;
   logic                  loadc;
   logic                  loads;
   logic [DATA_WIDTH-1:0] datapath_in;

   modport master (
      input  start, instr,
      output busy, done, err, readnum, writenum, write, vsel, loada, loadb,
             asel, bsel, shift, ALUop, loadc, loads, datapath_in
   );

   modport slave (
      output start, instr,
      input  busy, done, err, readnum, writenum, write, vsel, loada, loadb,
             asel, bsel, shift, ALUop, loadc, loads, datapath_in
   );
endinterface

// File: rtl/datapath_controller.sv
// Instruction sequencer: latches one instruction per start/done handshake and
// steps a Moore FSM that asserts one datapath stage per cycle.
module datapath_controller #(
   parameter int DATA_WIDTH  = 16,
   parameter bit SIGN_EXTEND = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   datapath_controller_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_GETA, ST_GETB, ST_EXEC, ST_WIMM, ST_WRC, ST_DONE
   } state_t;

   typedef enum logic [2:0] {
      K_MOVI, K_MOVR, K_ADD, K_AND, K_CMP, K_MVN, K_ILL
   } kind_t;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       err;
      logic [2:0] readnum;
      logic [2:0] writenum;
      logic       write;
      logic       vsel;
      logic       loada;
      logic       loadb;
      logic       asel;
      logic       bsel;
      logic [1:0] shift;
      logic [1:0] aluop;
      logic       loadc;
      logic       loads;
   } ctrl_t;

   state_t                r_state;
   logic [15:0]           r_instr;
   ctrl_t                 r_ctrl;
   state_t                w_nxt_state;
   logic [15:0]           w_nxt_instr;
   logic [DATA_WIDTH-1:0] w_imm_ext;

   function automatic kind_t kind_of(input logic [15:0] in);
      case ({in[15:13], in[12:11]})
         5'b110_10: kind_of = K_MOVI;
         5'b110_00: kind_of = K_MOVR;
         5'b101_00: kind_of = K_ADD;
         5'b101_10: kind_of = K_AND;
         5'b101_01: kind_of = K_CMP;
         5'b101_11: kind_of = K_MVN;
         default:   kind_of = K_ILL;
      endcase
   endfunction

   function automatic state_t first_state(input logic [15:0] in);
      case (kind_of(in))
         K_MOVI:        first_state = ST_WIMM;
         K_MOVR, K_MVN: first_state = ST_GETB;
         K_ILL:         first_state = ST_DONE;
         default:       first_state = ST_GETA;
      endcase
   endfunction

   // Controls for the state being entered; registering them keeps every
   // output glitch-free for the whole state.
   function automatic ctrl_t decode(input state_t s, input logic [15:0] in);
      ctrl_t c;
      kind_t k;
      c      = '0;
      k      = kind_of(in);
      c.busy = (s != ST_IDLE);
      case (s)
         ST_GETA: begin
            c.readnum = in[10:8];
            c.loada   = 1'b1;
         end
         ST_GETB: begin
            c.readnum = in[2:0];
            c.loadb   = 1'b1;
         end
         ST_EXEC: begin
            c.shift = in[4:3];
            c.asel  = (k == K_MOVR);
            case (k)
               K_AND:   c.aluop = 2'b10;
               K_CMP:   c.aluop = 2'b01;
               K_MVN:   c.aluop = 2'b11;
               default: c.aluop = 2'b00;
            endcase
            c.loadc = (k != K_CMP);
            c.loads = (k == K_CMP);
         end
         ST_WIMM: begin
            c.write    = 1'b1;
            c.vsel     = 1'b1;
            c.writenum = in[10:8];
         end
         ST_WRC: begin
            c.write    = 1'b1;
            c.writenum = in[7:5];
         end
         ST_DONE: begin
            c.done = 1'b1;
            c.err  = (k == K_ILL);
         end
         default: ;
      endcase
      return c;
   endfunction

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_instr = r_instr;
      case (r_state)
         ST_IDLE: if (bus.start) begin
            w_nxt_instr = bus.instr;
            w_nxt_state = first_state(bus.instr);
         end
         ST_GETA:         w_nxt_state = ST_GETB;
         ST_GETB:         w_nxt_state = ST_EXEC;
         ST_EXEC:         w_nxt_state = (kind_of(r_instr) == K_CMP) ? ST_DONE : ST_WRC;
         ST_WIMM, ST_WRC: w_nxt_state = ST_DONE;
         default:         w_nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_instr <= '0;
         r_ctrl  <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_instr <= w_nxt_instr;
         r_ctrl  <= decode(w_nxt_state, w_nxt_instr);
      end
   end

   // r_instr only changes on acceptance, so the immediate is held until the next one.
   assign w_imm_ext = SIGN_EXTEND ? {{(DATA_WIDTH-8){r_instr[7]}}, r_instr[7:0]}
                                  : {{(DATA_WIDTH-8){1'b0}},       r_instr[7:0]};

   assign bus.busy        = r_ctrl.busy;
   assign bus.done        = r_ctrl.done;
   assign bus.err         = r_ctrl.err;
   assign bus.readnum     = r_ctrl.readnum;
   assign bus.writenum    = r_ctrl.writenum;
   assign bus.write       = r_ctrl.write;
   assign bus.vsel        = r_ctrl.vsel;
   assign bus.loada       = r_ctrl.loada;
   assign bus.loadb       = r_ctrl.loadb;
   assign bus.asel        = r_ctrl.asel;
   assign bus.bsel        = r_ctrl.bsel;
   assign bus.shift       = r_ctrl.shift;
   assign bus.ALUop       = r_ctrl.aluop;
   assign bus.loadc       = r_ctrl.loadc;
   assign bus.loads       = r_ctrl.loads;
   assign bus.datapath_in = w_imm_ext;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench: per-cycle expected control vectors for each instruction
// class, plus hand sequences for back-to-back issue, latency and async reset.
module tb_datapath_controller;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   datapath_controller_if #(.DATA_WIDTH(16)) bus ();
   datapath_controller_if #(.DATA_WIDTH(16)) bus_z ();

   datapath_controller #(.DATA_WIDTH(16), .SIGN_EXTEND(1'b1)) u_dut (
      .clk(clk), .reset_n(rst_n), .bus(bus)
   );
   datapath_controller #(.DATA_WIDTH(16), .SIGN_EXTEND(1'b0)) u_dut_z (
      .clk(clk), .reset_n(rst_n), .bus(bus_z)
   );

   typedef struct packed {
      logic        busy, done, err;
      logic [2:0]  readnum, writenum;
      logic        write, vsel, loada, loadb, asel, bsel;
      logic [1:0]  shift, alu;
      logic        loadc, loads;
      logic [15:0] dp;
   } exp_t;

   typedef struct {
      logic        nw;
      logic [15:0] instr;
      exp_t        exp;
   } row_t;

   row_t tbl[$];

   function automatic exp_t snap();
      exp_t e;
      e = '{busy: bus.busy, done: bus.done, err: bus.err, readnum: bus.readnum,
            writenum: bus.writenum, write: bus.write, vsel: bus.vsel,
            loada: bus.loada, loadb: bus.loadb, asel: bus.asel, bsel: bus.bsel,
            shift: bus.shift, alu: bus.ALUop, loadc: bus.loadc,
            loads: bus.loads, dp: bus.datapath_in};
      return e;
   endfunction

   function automatic exp_t e_idle(input logic [15:0] dp);
      exp_t e = '0;
      e.dp = dp;
      return e;
   endfunction

   function automatic exp_t e_geta(input logic [2:0] rn, input logic [15:0] dp);
      exp_t e = e_idle(dp);
      e.busy = 1; e.readnum = rn; e.loada = 1;
      return e;
   endfunction

   function automatic exp_t e_getb(input logic [2:0] rm, input logic [15:0] dp);
      exp_t e = e_idle(dp);
      e.busy = 1; e.readnum = rm; e.loadb = 1;
      return e;
   endfunction

   function automatic exp_t e_exec(input logic [1:0] sh, input logic asel, input logic [1:0] alu,
                                   input logic lc, input logic ls, input logic [15:0] dp);
      exp_t e = e_idle(dp);
      e.busy = 1; e.shift = sh; e.asel = asel; e.alu = alu; e.loadc = lc; e.loads = ls;
      return e;
   endfunction

   function automatic exp_t e_wimm(input logic [2:0] rn, input logic [15:0] dp);
      exp_t e = e_idle(dp);
      e.busy = 1; e.write = 1; e.vsel = 1; e.writenum = rn;
      return e;
   endfunction

   function automatic exp_t e_wrc(input logic [2:0] rd, input logic [15:0] dp);
      exp_t e = e_idle(dp);
      e.busy = 1; e.write = 1; e.writenum = rd;
      return e;
   endfunction

   function automatic exp_t e_done(input logic err, input logic [15:0] dp);
      exp_t e = e_idle(dp);
      e.busy = 1; e.done = 1; e.err = err;
      return e;
   endfunction

   task automatic add(input logic nw, input logic [15:0] instr, input exp_t exp);
      row_t r;
      r.nw = nw; r.instr = instr; r.exp = exp;
      tbl.push_back(r);
   endtask

   task automatic chk(input string nm, input exp_t act, input exp_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        prev_busy;
      int          n;
      logic [11:0] pat;

      bus.start = 0; bus.instr = 0; bus_z.start = 0; bus_z.instr = 0;

      // MOV R0,#7
      add(1, 16'hD007, e_wimm(3'd0, 16'h0007));
      add(0, 0, e_done(0, 16'h0007));
      add(0, 0, e_idle(16'h0007));
      // MOV R1,#-2 (sign-extended)
      add(1, 16'hD1FE, e_wimm(3'd1, 16'hFFFE));
      add(0, 0, e_done(0, 16'hFFFE));
      add(0, 0, e_idle(16'hFFFE));
      // ADD R2,R1,R0 LSL
      add(1, 16'hA148, e_geta(3'd1, 16'h0048));
      add(0, 0, e_getb(3'd0, 16'h0048));
      add(0, 0, e_exec(2'b01, 0, 2'b00, 1, 0, 16'h0048));
      add(0, 0, e_wrc(3'd2, 16'h0048));
      add(0, 0, e_done(0, 16'h0048));
      add(0, 0, e_idle(16'h0048));
      // CMP R0,R1
      add(1, 16'hA801, e_geta(3'd0, 16'h0001));
      add(0, 0, e_getb(3'd1, 16'h0001));
      add(0, 0, e_exec(2'b00, 0, 2'b01, 0, 1, 16'h0001));
      add(0, 0, e_done(0, 16'h0001));
      add(0, 0, e_idle(16'h0001));
      // illegal opcode 111
      add(1, 16'hE000, e_done(1, 16'h0000));
      add(0, 0, e_idle(16'h0000));
      // AND R7,R2,R3
      add(1, 16'hB2E3, e_geta(3'd2, 16'hFFE3));
      add(0, 0, e_getb(3'd3, 16'hFFE3));
      add(0, 0, e_exec(2'b00, 0, 2'b10, 1, 0, 16'hFFE3));
      add(0, 0, e_wrc(3'd7, 16'hFFE3));
      add(0, 0, e_done(0, 16'hFFE3));
      add(0, 0, e_idle(16'hFFE3));
      // MVN R5,R2 sh=10
      add(1, 16'hBCB2, e_getb(3'd2, 16'hFFB2));
      add(0, 0, e_exec(2'b10, 0, 2'b11, 1, 0, 16'hFFB2));
      add(0, 0, e_wrc(3'd5, 16'hFFB2));
      add(0, 0, e_done(0, 16'hFFB2));
      add(0, 0, e_idle(16'hFFB2));
      // MOV R3,R5 sh=11
      add(1, 16'hC07D, e_getb(3'd5, 16'h007D));
      add(0, 0, e_exec(2'b11, 1, 2'b00, 1, 0, 16'h007D));
      add(0, 0, e_wrc(3'd3, 16'h007D));
      add(0, 0, e_done(0, 16'h007D));
      add(0, 0, e_idle(16'h007D));
      // illegal 110/01
      add(1, 16'hC800, e_done(1, 16'h0000));
      add(0, 0, e_idle(16'h0000));

      // reset state and quiet idle
      repeat (2) @(negedge clk);
      chk("reset", snap(), e_idle(16'h0000));
      chk_int("reset_z_busy", int'(bus_z.busy), 0);
      rst_n = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("idle%0d", i), snap(), e_idle(16'h0000));
      end

      // Vector table; start/instr are scrambled in busy cycles and must be ignored.
      prev_busy = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].nw) begin
            bus.start = 1; bus.instr = tbl[i].instr;
         end else begin
            bus.start = prev_busy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.instr = 16'($urandom);
         end
         @(posedge clk); #1;
         bus.start = 0;
         @(negedge clk);
         chk($sformatf("vec%0d_%h", i, tbl[i].instr), snap(), tbl[i].exp);
         prev_busy = tbl[i].exp.busy;
      end

      // start held high: WIMM, DONE, one IDLE, then the next WIMM
      bus.start = 1; bus.instr = 16'hD007;
      pat = 12'b10_11_00_10_11_00;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk_int($sformatf("b2b%0d", i), int'({bus.busy, bus.done}), int'(pat[11-2*i -: 2]));
      end
      bus.start = 0;

      // acceptance-to-done latency of ADD
      @(negedge clk);
      bus.start = 1; bus.instr = 16'hA148;
      @(posedge clk); #1;
      bus.start = 0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (bus.done) break;
      end
      chk_int("add_latency", n, 5);
      @(negedge clk);

      // async reset during EXEC kills the sequence
      bus.start = 1; bus.instr = 16'hA148;
      @(posedge clk); #1;
      bus.start = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("pre_reset_exec", snap(), e_exec(2'b01, 0, 2'b00, 1, 0, 16'h0048));
      #2 rst_n = 0;
      #1 chk("async_reset", snap(), e_idle(16'h0000));
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("post_reset%0d", i), snap(), e_idle(16'h0000));
      end

      // zero-extend instance
      bus_z.start = 1; bus_z.instr = 16'hD1FE;
      @(posedge clk); #1;
      bus_z.start = 0;
      @(negedge clk);
      chk_int("zext_dp", int'(bus_z.datapath_in), 16'h00FE);
      chk_int("zext_write", int'({bus_z.write, bus_z.vsel, bus_z.writenum}), 5'b11_001);
      @(negedge clk);
      chk_int("zext_done", int'({bus_z.done, bus_z.err}), 2'b10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
